// File: rtl/uart_rx_pkg.sv
// Constants shared by the UART receiver and transmitter: state encoding and
// default baud-rate settings.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam int CLK_FREQ   = 50_000_000;
   localparam int BAUD       = 19200;
   localparam int OVERSAMPLE = 16;

   // Rounded to the nearest integer so the baud error stays symmetric.
   function automatic int calc_m(input int clk_freq, input int baud);
      return (clk_freq + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
   endfunction

   localparam int DEFAULT_M = calc_m(CLK_FREQ, BAUD);

endpackage

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversample tick generator: one-cycle s_tick every M clocks.
module baud_rate_gen #(
   parameter int M = 163
) (
   input  logic CLK,
   input  logic RESET,
   output logic s_tick
);

   localparam int CW = (M > 1) ? $clog2(M) : 1;
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge CLK) begin
      if (RESET)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign s_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling; good bytes go to dout with rx_done_tick,
// malformed frames are dropped and flagged with an error pulse.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int M          = DEFAULT_M,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            rx,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err_tick,
   output logic            parity_err_tick,
   output state_t          dbg_state
);

   // Must hold both 15 (data/parity bits) and SB_TICK-1 (stop phase).
   localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
   localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
   localparam logic [SW-1:0] S_MID  = SW'(7);
   localparam logic [SW-1:0] S_LAST = SW'(15);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic          PAR_ODD = 1'(PARITY_ODD);

   logic            rx_meta, rx_s, s_tick;
   state_t          state_reg, state_next;
   logic [SW-1:0]   s_reg, s_next;
   logic [NW-1:0]   n_reg, n_next;
   logic [DBIT-1:0] b_reg, b_next;
   logic            p_reg, p_next;
   logic [DBIT-1:0] dout_next;
   logic            done_next, ferr_next, perr_next;

   baud_rate_gen #(.M(M)) u_baud (
      .CLK    (CLK),
      .RESET  (RESET),
      .s_tick (s_tick)
   );

   // Synchronizer resets high so an idle line cannot look like a start bit.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_reg       <= IDLE;
         s_reg           <= '0;
         n_reg           <= '0;
         b_reg           <= '0;
         p_reg           <= 1'b0;
         dout            <= '0;
         rx_done_tick    <= 1'b0;
         frame_err_tick  <= 1'b0;
         parity_err_tick <= 1'b0;
      end else begin
         state_reg       <= state_next;
         s_reg           <= s_next;
         n_reg           <= n_next;
         b_reg           <= b_next;
         p_reg           <= p_next;
         dout            <= dout_next;
         rx_done_tick    <= done_next;
         frame_err_tick  <= ferr_next;
         parity_err_tick <= perr_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      s_next     = s_reg;
      n_next     = n_reg;
      b_next     = b_reg;
      p_next     = p_reg;
      dout_next  = dout;
      done_next  = 1'b0;
      ferr_next  = 1'b0;
      perr_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_reg == S_MID) begin
                  s_next = '0;
                  n_next = '0;
                  state_next = rx_s ? IDLE : DATA;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next = '0;
                  b_next = {rx_s, b_reg[DBIT-1:1]};
                  if (n_reg == N_LAST)
                     state_next = (PARITY_EN != 0) ? PARITY : STOP;
                  else
                     n_next = n_reg + 1'b1;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_reg == S_LAST) begin
                  s_next     = '0;
                  p_next     = rx_s;
                  state_next = STOP;
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_reg == S_STOP) begin
                  state_next = IDLE;
                  // Frame error outranks parity error; only one pulse per frame.
                  if (!rx_s)
                     ferr_next = 1'b1;
                  else if ((PARITY_EN != 0) && ((^b_reg ^ p_reg) != PAR_ODD))
                     perr_next = 1'b1;
                  else begin
                     dout_next = b_reg;
                     done_next = 1'b1;
                  end
               end else begin
                  s_next = s_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign dbg_state = state_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with M=4: an 8N1 receiver and an 8E1 receiver,
// each checked by a scoreboard queue popped by its own monitor.
module tb_uart_rx;
   import uart_rx_pkg::*;

   logic CLK = 1'b0;
   logic RESET = 1'b1;
   logic rx = 1'b1;
   logic rx_p = 1'b1;

   logic [7:0] dout, dout_p;
   logic       done, ferr, perr, done_p, ferr_p, perr_p;
   state_t     dbg_state, dbg_state_p;

   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   longint last_done = 0;

   // Entry: {expected pulse one-hot {parity,frame,done}, expected dout, check 640-CLK gap}
   logic [11:0] exp_q[$];
   logic [11:0] exp_qp[$];

   uart_rx #(.DBIT(8), .SB_TICK(16), .M(4), .PARITY_EN(0), .PARITY_ODD(0)) dut (
      .CLK(CLK), .RESET(RESET), .rx(rx), .dout(dout), .rx_done_tick(done),
      .frame_err_tick(ferr), .parity_err_tick(perr), .dbg_state(dbg_state)
   );

   uart_rx #(.DBIT(8), .SB_TICK(16), .M(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
      .CLK(CLK), .RESET(RESET), .rx(rx_p), .dout(dout_p), .rx_done_tick(done_p),
      .frame_err_tick(ferr_p), .parity_err_tick(perr_p), .dbg_state(dbg_state_p)
   );

   // Clock and cycle counter
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Driver tasks (64 CLK per bit)
   task automatic send_bit(input bit p, input logic v, input int n);
      if (p) rx_p = v; else rx = v;
      repeat (n) @(negedge CLK);
   endtask

   task automatic send_frame(input bit p, input logic [7:0] d, input bit has_par,
                             input logic par, input bit stop_ok);
      send_bit(p, 1'b0, 64);
      for (int i = 0; i < 8; i++) send_bit(p, d[i], 64);
      if (has_par) send_bit(p, par, 64);
      if (stop_ok) send_bit(p, 1'b1, 64);
      else begin
         send_bit(p, 1'b0, 48);
         send_bit(p, 1'b1, 16);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Monitor for the 8N1 receiver
   always @(negedge CLK) begin : mon
      logic [11:0] e;
      if (!RESET && (done || ferr || perr)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", {29'd0, perr, ferr, done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", {29'd0, perr, ferr, done}, {29'd0, e[11:9]});
            check("dout", {24'd0, dout}, {24'd0, e[8:1]});
            if (e[0]) check("back_to_back_gap", 32'(cyc - last_done), 32'd640);
         end
         if (done) last_done = cyc;
      end
   end

   // Monitor for the 8E1 receiver
   always @(negedge CLK) begin : mon_p
      logic [11:0] e;
      if (!RESET && (done_p || ferr_p || perr_p)) begin
         if (exp_qp.size() == 0) begin
            check("unexpected_pulse_p", {29'd0, perr_p, ferr_p, done_p}, 32'd0);
         end else begin
            e = exp_qp.pop_front();
            check("pulse_kind_p", {29'd0, perr_p, ferr_p, done_p}, {29'd0, e[11:9]});
            check("dout_p", {24'd0, dout_p}, {24'd0, e[8:1]});
         end
      end
   end

   initial begin
      RESET = 1'b1;
      idle(5);
      RESET = 1'b0;
      idle(20);
      check("reset_dout", {24'd0, dout}, 32'd0);
      check("reset_pulses", {29'd0, perr, ferr, done}, 32'd0);
      check("reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
      check("reset_dout_p", {24'd0, dout_p}, 32'd0);

      // 0x55 as 8N1
      exp_q.push_back({3'b001, 8'h55, 1'b0});
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      idle(100);

      // 12-CLK glitch on the line
      rx = 1'b0;
      idle(12);
      rx = 1'b1;
      idle(100);
      check("glitch_dout", {24'd0, dout}, 32'h55);
      check("glitch_state", {29'd0, dbg_state}, {29'd0, IDLE});

      // 0xA3 with a low stop bit
      exp_q.push_back({3'b010, 8'h55, 1'b0});
      send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
      idle(100);

      // Even parity: 0x07 needs parity bit 1
      exp_qp.push_back({3'b100, 8'h00, 1'b0});
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      idle(100);
      exp_qp.push_back({3'b001, 8'h07, 1'b0});
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      idle(100);

      // Back-to-back 0x00 then 0xFF
      exp_q.push_back({3'b001, 8'h00, 1'b0});
      exp_q.push_back({3'b001, 8'hFF, 1'b1});
      send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      idle(100);

      // Reset during data bit 4 of 0x96 (LSB-first bits 0..3 = 0,1,1,0)
      send_bit(1'b0, 1'b0, 64);
      send_bit(1'b0, 1'b0, 64);
      send_bit(1'b0, 1'b1, 64);
      send_bit(1'b0, 1'b1, 64);
      send_bit(1'b0, 1'b0, 64);
      send_bit(1'b0, 1'b1, 32);
      RESET = 1'b1;
      idle(3);
      RESET = 1'b0;
      idle(100);
      check("midframe_reset_dout", {24'd0, dout}, 32'd0);
      check("midframe_reset_dout_p", {24'd0, dout_p}, 32'd0);
      check("midframe_reset_state", {29'd0, dbg_state}, {29'd0, IDLE});
      exp_q.push_back({3'b001, 8'h3C, 1'b0});
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      idle(100);

      check("expected_left", exp_q.size(), 32'd0);
      check("expected_left_p", exp_qp.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: recovers serial frames (start, DBIT data LSB-first, optional parity, stop) from the asynchronous `rx` line using 16x oversampling.
- Contains its own baud-rate tick generator.
- Sits directly upstream of the RX FIFO. `rx_done_tick` drives the FIFO `wr` input and `dout` drives `w_data`.
- Malformed frames are dropped and flagged; they never reach the FIFO.

Parameters:
- DBIT, 8: number of data bits per frame.
- SB_TICK, 16: oversample ticks in the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2).
- M, 163: clock cycles per oversample tick (50 MHz / (19200*16)).
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- dout  output  DBIT  last correctly received byte.
- rx_done_tick  output  1  one-cycle pulse: `dout` holds a new valid byte.
- frame_err_tick  output  1  one-cycle pulse: stop bit sampled low, byte dropped.
- parity_err_tick  output  1  one-cycle pulse: parity mismatch, byte dropped.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; tick counter=0; sample counter=0; bit counter=0; shift register=0.
  - `dout`=0; all tick outputs 0.
  - Both synchronizer flops = 1, so no false start comes out of reset.
- Reset asserted mid-frame: the frame is abandoned with no pulse on any output.
- Input synchronizer: 2-FF chain on `rx`; the FSM sees only the synchronized value `rx_s`.
- Baud tick generator:
  - Free-running counter 0..M-1.
  - `s_tick`=1 for one cycle when counter==M-1, then the counter wraps to 0.
  - Runs in every FSM state.
- FSM (`s_cnt`: 4-bit sample counter; `n_cnt`: bit counter):
  - IDLE: `rx_s`==0 -> START, `s_cnt`=0.
  - START: on each `s_tick`, `s_cnt`++.
    - At `s_cnt`==7 (mid start bit): if `rx_s`==0 -> DATA with `s_cnt`=0, `n_cnt`=0.
    - If `rx_s`==1 at that point it was a glitch -> IDLE, no output.
  - DATA: on `s_tick`, when `s_cnt`==15:
    - Shift `rx_s` into the MSB of the shift register (shift right), `s_cnt`=0.
    - When `n_cnt`==DBIT-1 -> PARITY if PARITY_EN else STOP; otherwise `n_cnt`++.
  - PARITY: on `s_tick`, when `s_cnt`==15: latch `rx_s` as the parity bit -> STOP, `s_cnt`=0.
  - STOP: on `s_tick`, when `s_cnt`==SB_TICK-1 -> IDLE, then exactly one of:
    - `rx_s`==0: assert `frame_err_tick`.
    - else parity enabled and XOR(data, parity bit) != PARITY_ODD: assert `parity_err_tick`.
    - else: `dout` <= shift register and assert `rx_done_tick`.
- Stop-phase counter width: `s_cnt` must be wide enough for SB_TICK-1. Size it to clog2(SB_TICK).
- Output timing:
  - All outputs are registered.
  - Pulses are high in the cycle immediately after the qualifying `s_tick` edge, for exactly one CLK cycle.
- `dout` stability: changes only together with `rx_done_tick`; unchanged on error or reset-free idle.
- Back-to-back frames: from IDLE, a start edge is accepted on the first `rx_s`==0, so no idle gap is required after the stop bit.
- Priority: frame error wins over parity error; at most one of the three pulses per frame.

Decomposition:
- Shared package holds:
  - State encoding constants IDLE/START/DATA/PARITY/STOP (2'b/3'b localparams).
  - Default baud constants (CLK_FREQ, BAUD, OVERSAMPLE=16, derived M).
- The UART TX reuses these constants.
- One natural sub-module: `baud_rate_gen` (parameter M; ports CLK, RESET, `s_tick`). It is instantiated here and reused by the TX.

Test Plan (M=4, so a bit lasts 64 CLK; DBIT=8, SB_TICK=16 unless stated):
1. Send 0x55 as 8N1 -> exactly one `rx_done_tick`, `dout`=0x55, no error pulses; FIFO downstream shows empty deasserting.
2. `rx` low for 12 CLK, then high -> FSM returns to IDLE at the mid-start sample; no output pulses; `dout` unchanged.
3. Send 0xA3 with the stop bit driven low -> one `frame_err_tick`, no `rx_done_tick`, `dout` keeps its previous value.
4. PARITY_EN=1, even parity:
   - 0x07 with parity bit 0 -> one `parity_err_tick`.
   - 0x07 with parity bit 1 -> `rx_done_tick`, `dout`=0x07.
5. 0x00 then 0xFF with no idle gap after the stop bit -> two `rx_done_tick` pulses 640 CLK apart, `dout` 0x00 then 0xFF.
6. Assert RESET during data bit 4 of 0x96 -> no pulses, `dout`=0x00; the next frame 0x3C is received correctly (`dout`=0x3C).
